// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and helpers for the multi-cycle HI/LO multiply/divide unit.
// Op codes match the ALU's alu_control field so decode can feed both blocks from one field.
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int ITERS_DEF = WIDTH_DEF;
  localparam int CNT_W     = $clog2(ITERS_DEF);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic op_valid(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
// Multiply keeps {partial, multiplier}; divide keeps {remainder, dividend/quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               i_is_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;

  assign w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  assign w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_rem_sh - {1'b0, i_opnd};

  // A clear top bit of w_diff means the trial subtraction did not borrow.
  always_comb begin
    o_acc = {w_sum, i_acc[WIDTH-1:1]};
    if (i_is_div) begin
      if (!w_diff[WIDTH])
        o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
      else
        o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Works on magnitudes for ITERS cycles, then applies signs in FIX and commits HI/LO.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITERS = ITERS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_op1;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_a;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  always_comb begin
    w_a_neg = op_signed(op) & op1[WIDTH-1];
    w_b_neg = op_signed(op) & op2[WIDTH-1];
    w_abs_a = w_a_neg ? -op1 : op1;
    w_abs_b = w_b_neg ? -op2 : op2;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_nxt)
  );

  // Quotient follows the sign product, remainder follows the dividend; divide-by-zero is forced.
  always_comb begin
    w_prod   = r_neg_res ? -r_acc : r_acc;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_dz) begin
        w_res_hi = r_op1;
        w_res_lo = '1;
      end else begin
        w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_res_hi = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_op1      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_a    <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mthi) r_hi <= mt_data;
          if (mtlo) r_lo <= mt_data;
          if (start && op_valid(op)) begin
            r_is_div  <= op_is_div(op);
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_a   <= w_a_neg;
            r_op1     <= op1;
            r_dz      <= op_is_div(op) && (op2 == '0);
            r_acc     <= op_is_div(op) ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            r_opnd    <= op_is_div(op) ? w_abs_b : w_abs_a;
            r_cnt     <= '0;
            r_state   <= ITER;
          end
        end
        ITER: begin
          if (cancel) begin
            r_state <= IDLE;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(ITERS - 1)) r_state <= FIX;
          end
        end
        FIX: begin
          r_state <= IDLE;
          if (!cancel) begin
            r_hi       <= w_res_hi;
            r_lo       <= w_res_lo;
            r_done     <= 1'b1;
            r_div_zero <= r_dz;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus random ops against a plain-arithmetic model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        cancel = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] mt_data = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  int   res_done_cyc;
  int   res_busy_cnt;
  int   res_done_cnt;
  logic res_dz;
  logic res_busy_after_inj;

  muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .op1(op1), .op2(op2),
    .cancel(cancel), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic model(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] ehi, output logic [31:0] elo, output logic edz);
    longint sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    edz = 1'b0;
    ehi = '0;
    elo = '0;
    if (mop == OP_MULT) begin
      p = sa * sb;
      ehi = p[63:32];
      elo = p[31:0];
    end else if (mop == OP_MULTU) begin
      up = ua * ub;
      ehi = up[63:32];
      elo = up[31:0];
    end else if (b == 32'h0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
      edz = 1'b1;
    end else if (mop == OP_DIV) begin
      p = sa / sb;
      elo = p[31:0];
      p = sa % sb;
      ehi = p[31:0];
    end else begin
      up = ua / ub;
      elo = up[31:0];
      up = ua % ub;
      ehi = up[31:0];
    end
  endtask

  // Issues one op and watches 45 cycles; inj_kind 1 = start+mthi collision, 2 = cancel.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input int inj_kind);
    op = o; op1 = a; op2 = b; start = 1'b1;
    res_done_cyc = 0; res_busy_cnt = 0; res_done_cnt = 0; res_dz = 1'b0; res_busy_after_inj = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (busy) res_busy_cnt++;
      if (done) begin
        res_done_cnt++;
        if (res_done_cyc == 0) begin
          res_done_cyc = cyc;
          res_dz = div_zero;
        end
      end
      if (inj_kind == 2 && cyc == inj_cyc + 1) res_busy_after_inj = busy;
      cancel = 1'b0; mthi = 1'b0; start = 1'b0;
      if (cyc == inj_cyc && inj_kind == 1) begin
        start = 1'b1; op = OP_DIVU; op1 = 32'd99; op2 = 32'd3; mthi = 1'b1; mt_data = 32'hAA;
      end
      if (cyc == inj_cyc && inj_kind == 2) cancel = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {busy, done, div_zero}); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mult_signed;
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, 0);
    n_checks++; if (res_done_cyc !== 34) begin n_fail++; $display("FAIL mult_latency: got %0d expected 34", res_done_cyc); end
    n_checks++; if (res_busy_cnt !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 33", res_busy_cnt); end
    n_checks++; if (res_done_cnt !== 1) begin n_fail++; $display("FAIL mult_done_pulses: got %0d expected 1", res_done_cnt); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff1", lo); end
    n_checks++; if (res_dz !== 1'b0) begin n_fail++; $display("FAIL mult_div_zero: got %b expected 0", res_dz); end
  endtask

  task automatic test_multu;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
  endtask

  task automatic test_div;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", hi); end
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 0);
    n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %0d expected 14", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %0d expected 2", hi); end
  endtask

  task automatic test_div_zero;
    run_op(OP_DIVU, 32'h1234_5678, 32'h0, 0, 0);
    n_checks++; if (res_done_cyc !== 34) begin n_fail++; $display("FAIL divz_latency: got %0d expected 34", res_done_cyc); end
    n_checks++; if (res_dz !== 1'b1) begin n_fail++; $display("FAIL divz_flag: got %b expected 1", res_dz); end
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL divz_hi: got %h expected 12345678", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divz_lo: got %h expected ffffffff", lo); end
    n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL divz_pulse: got %b expected 0", div_zero); end
    run_op(OP_DIV, 32'hFFFF_FF00, 32'h0, 0, 0);
    n_checks++; if (hi !== 32'hFFFF_FF00) begin n_fail++; $display("FAIL divz_signed_hi: got %h expected ffffff00", hi); end
    n_checks++; if (res_dz !== 1'b1) begin n_fail++; $display("FAIL divz_signed_flag: got %b expected 1", res_dz); end
  endtask

  task automatic test_overflow;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL ovf_hi: got %h expected 0", hi); end
    n_checks++; if (res_dz !== 1'b0) begin n_fail++; $display("FAIL ovf_div_zero: got %b expected 0", res_dz); end
  endtask

  task automatic test_invalid_op;
    op = 4'b0010; op1 = 32'd3; op2 = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL invalid_op_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL invalid_op_hi: got %h expected 0", hi); end
  endtask

  task automatic test_collision;
    run_op(OP_MULT, 32'd6, 32'd7, 5, 1);
    n_checks++; if (res_done_cnt !== 1) begin n_fail++; $display("FAIL coll_done_pulses: got %0d expected 1", res_done_cnt); end
    n_checks++; if (res_done_cyc !== 34) begin n_fail++; $display("FAIL coll_latency: got %0d expected 34", res_done_cyc); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL coll_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL coll_lo: got %0d expected 42", lo); end
  endtask

  task automatic test_mtlo;
    mtlo = 1'b1; mt_data = 32'h55;
    @(posedge clk); #1;
    mtlo = 1'b0;
    n_checks++; if (lo !== 32'h55) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 55", lo); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL mtlo_hi: got %h expected 0", hi); end
  endtask

  task automatic test_mthi_with_start;
    int waited;
    op = OP_MULTU; op1 = 32'd2; op2 = 32'd3; start = 1'b1; mthi = 1'b1; mt_data = 32'h1234;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    n_checks++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi_start_hi: got %h expected 1234", hi); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mthi_start_busy: got %b expected 1", busy); end
    waited = 0;
    while (!done && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mthi_start_done: got %b expected 1 within 60 cycles", done); end
    n_checks++; if ({hi, lo} !== {32'h0, 32'd6}) begin n_fail++; $display("FAIL mthi_start_result: got %h_%h expected 0_6", hi, lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel;
    logic [31:0] pre_hi, pre_lo;
    pre_hi = hi; pre_lo = lo;
    run_op(OP_DIV, 32'd1000, 32'd9, 10, 2);
    n_checks++; if (res_done_cnt !== 0) begin n_fail++; $display("FAIL cancel_done: got %0d pulses expected 0", res_done_cnt); end
    n_checks++; if (res_busy_after_inj !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", res_busy_after_inj); end
    n_checks++; if ({hi, lo} !== {pre_hi, pre_lo}) begin n_fail++; $display("FAIL cancel_hilo: got %h_%h expected %h_%h", hi, lo, pre_hi, pre_lo); end
  endtask

  task automatic test_random;
    logic [3:0]  ops [4];
    logic [3:0]  o;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
    for (int i = 0; i < 16; i++) begin
      o = ops[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: b = $urandom;
      endcase
      model(o, a, b, ehi, elo, edz);
      run_op(o, a, b, 0, 0);
      n_checks++; if ({hi, lo, res_dz} !== {ehi, elo, edz} || res_done_cyc !== 34) begin
        n_fail++;
        $display("FAIL rand_%0d op=%b a=%h b=%h: got hi=%h lo=%h dz=%b cyc=%0d expected hi=%h lo=%h dz=%b cyc=34",
                 i, o, a, b, hi, lo, res_dz, res_done_cyc, ehi, elo, edz);
      end
    end
  endtask

  task automatic test_async_reset;
    op = OP_MULT; op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, done, div_zero} !== 3'b000) begin n_fail++; $display("FAIL arst_ctrl: got %b expected 000", {busy, done, div_zero}); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL arst_hilo: got %h_%h expected 0_0", hi, lo); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_discard: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_div_zero();
    test_overflow();
    run_op(OP_MULTU, 32'h0, 32'h0, 0, 0);
    test_invalid_op();
    test_collision();
    test_mtlo();
    test_mthi_with_start();
    run_op(OP_DIVU, 32'd100, 32'd7, 0, 0);
    test_cancel();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the MIPS core. It replaces single-cycle `*`, `/` and `%` with a 32-iteration shift-add multiplier and a restoring divider. It drives busy so the decode/hazard logic can stall MFHI/MFLO and further mult/div issue. Operation codes reuse the ALU's 4-bit alu_control encoding, so decode can drive both blocks from the same field.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERS, 32, iteration cycles per operation (equals WIDTH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue request, sampled only when busy=0
op  in  4  0000 MULT, 1001 MULTU, 1101 DIV, 1100 DIVU; other codes ignored
op1  in  WIDTH  multiplicand / dividend (rs)
op2  in  WIDTH  multiplier / divisor (rt)
cancel  in  1  synchronous abort of an in-flight operation
mthi  in  1  write HI from mt_data
mtlo  in  1  write LO from mt_data
mt_data  in  WIDTH  MTHI/MTLO data
busy  out  1  operation in flight
done  out  1  one-cycle pulse, HI/LO valid with new result
div_zero  out  1  valid with done: last op was DIV/DIVU with op2=0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; all internal accumulators cleared. Reset mid-operation discards the operation with no HI/LO update.
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE: on start=1 with a valid op, latch |op1| and |op2| (raw values for unsigned ops), the sign flags and the op. Counter=0. Next state is ITER. busy=1 from the following cycle. Invalid op: no action.
- ITER: one step per cycle for ITERS cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring subtract-shift producing quotient and remainder.
  - Counter increments each cycle. Move to FIX after count ITERS-1.
- FIX: apply signs.
  - Signed product is negated when sign(op1)!=sign(op2).
  - Signed quotient is negated when the signs differ; remainder takes the sign of op1.
  - HI/LO are written at the clock edge that leaves FIX. done=1 and busy=0 in the next cycle.
- Latency: start sampled at edge 0; done high in cycle ITERS+2 (34). busy is high for 33 cycles.
- Results: MULT/MULTU give HI=product[63:32], LO=product[31:0]. DIV/DIVU give LO=quotient, HI=remainder.
- Divide by zero: still full latency. HI=op1 (original), LO=32'hFFFFFFFF, div_zero=1 with done, for both signed and unsigned.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, div_zero=0.
- start while busy=1: ignored; no queueing.
- cancel: when busy=1, return to IDLE next cycle; HI/LO unchanged, no done. When busy=0, no effect. cancel and start in the same cycle: start wins if idle.
- mthi/mtlo: honoured only when busy=0, written at the next edge. When asserted with start in the same cycle, the write happens and the op launches; its result later overwrites HI/LO. Ignored while busy=1.
- done and div_zero are one-cycle pulses, 0 otherwise.

Decomposition:
- Package muldiv_pkg holds:
  - op-code constants OP_MULT=4'b0000, OP_MULTU=4'b1001, OP_DIV=4'b1101, OP_DIVU=4'b1100, kept identical to the ALU's alu_control codes.
  - enum state_t {IDLE, ITER, FIX}.
  - localparam CNT_W=$clog2(ITERS).
- One natural sub-module, muldiv_step: a purely combinational single iteration (shift-add or restoring subtract), instantiated once. The FSM, counter, sign fix and HI/LO stay in muldiv_seq.

Test Plan:
- MULT op1=0xFFFFFFFD (-3), op2=5 -> done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU op1=op2=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV op1=0xFFFFFFF9 (-7), op2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 100/7 -> LO=14, HI=2.
- DIVU op1=0x12345678, op2=0 -> HI=0x12345678, LO=0xFFFFFFFF, div_zero=1 together with done.
- Collisions:
  - MULT 6*7 started, second start and mthi (0xAA) at cycle 5 -> both ignored; HI=0, LO=42.
  - Then mtlo=0x55 while idle -> lo=0x55 next cycle.
- Aborts:
  - cancel at cycle 10 of a DIV -> no done, HI/LO keep prior values, busy=0 next cycle.
  - rst_n low mid-MULT -> all outputs 0 immediately (async).
